// File: rtl/inst_sram_responder.sv
// rtl/inst_sram_responder.sv - instruction SRAM-like responder backed by an on-chip word array
module inst_sram_responder #(
    parameter logic [31:0] ADDR_BASE  = 32'h1fc0_0000,
    parameter int          DEPTH_LOG2 = 14,
    parameter logic [31:0] ERR_WORD   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inst_sram_en,
    input  logic [3:0]  inst_sram_wen,
    input  logic [31:0] inst_sram_addr,
    input  logic [31:0] inst_sram_wdata,
    output logic [31:0] inst_sram_rdata,
    output logic        addr_err,
    output logic [31:0] rd_cnt
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [31:0]           mem [0:DEPTH-1];
    logic [31:0]           phys;
    logic [31:0]           off;
    logic [DEPTH_LOG2-1:0] idx;
    logic                  in_range;
    logic                  rd_req;
    logic                  wr_req;
    logic                  unused_ok;

    // kseg0/kseg1 aliases collapse onto the same physical window
    assign phys     = {3'b000, inst_sram_addr[28:0]};
    assign off      = phys - ADDR_BASE;
    assign idx      = off[DEPTH_LOG2+1:2];
    assign in_range = (off[31:DEPTH_LOG2+2] == '0) && (inst_sram_addr[1:0] == 2'b00);
    assign rd_req   = inst_sram_en && (inst_sram_wen == 4'b0000);
    assign wr_req   = inst_sram_en && (inst_sram_wen != 4'b0000) && in_range;

    assign unused_ok = &{1'b0, inst_sram_addr[31:29], off[1:0]};

    // Array is deliberately not reset so boot contents survive a core reset
    always_ff @(posedge clk) begin
        if (!reset && wr_req) begin
            for (int i = 0; i < 4; i++) begin
                if (inst_sram_wen[i]) begin
                    mem[idx][8*i +: 8] <= inst_sram_wdata[8*i +: 8];
                end
            end
        end
    end

    // Read-first output register; holding rdata while idle relies on en alone
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inst_sram_rdata <= 32'h0000_0000;
            addr_err        <= 1'b0;
            rd_cnt          <= 32'h0000_0000;
        end else begin
            addr_err <= 1'b0;
            if (inst_sram_en) begin
                if (in_range) begin
                    inst_sram_rdata <= mem[idx];
                end else begin
                    inst_sram_rdata <= ERR_WORD;
                    addr_err        <= 1'b1;
                end
                if (rd_req) begin
                    rd_cnt <= rd_cnt + 32'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_inst_sram_responder.sv
// tb/tb_inst_sram_responder.sv - randomized self-checking bench for inst_sram_responder
module tb_inst_sram_responder;

    localparam logic [31:0] ADDR_BASE = 32'h1fc0_0000;
    localparam logic [31:0] ERR_WORD  = 32'h0000_0000;
    localparam logic [31:0] WIN_BYTES = 32'h0001_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        inst_sram_en = 1'b0;
    logic [3:0]  inst_sram_wen = 4'b0;
    logic [31:0] inst_sram_addr = 32'h0;
    logic [31:0] inst_sram_wdata = 32'h0;
    logic [31:0] inst_sram_rdata;
    logic        addr_err;
    logic [31:0] rd_cnt;

    int tests_run = 0;
    int tests_failed = 0;

    logic [31:0] mref [int];
    logic [31:0] exp_rdata = 32'h0;
    logic        exp_err = 1'b0;
    logic [31:0] exp_cnt = 32'h0;

    inst_sram_responder #(
        .ADDR_BASE(ADDR_BASE),
        .DEPTH_LOG2(14),
        .ERR_WORD(ERR_WORD)
    ) dut (
        .clk(clk),
        .reset(reset),
        .inst_sram_en(inst_sram_en),
        .inst_sram_wen(inst_sram_wen),
        .inst_sram_addr(inst_sram_addr),
        .inst_sram_wdata(inst_sram_wdata),
        .inst_sram_rdata(inst_sram_rdata),
        .addr_err(addr_err),
        .rd_cnt(rd_cnt)
    );

    always #5 clk = ~clk;

    function automatic bit ok_addr(input logic [31:0] a);
        logic [31:0] o;
        o = {3'b000, a[28:0]} - ADDR_BASE;
        return (o < WIN_BYTES) && (a[1:0] == 2'b00);
    endfunction

    function automatic int word_of(input logic [31:0] a);
        return int'(({3'b000, a[28:0]} - ADDR_BASE) >> 2);
    endfunction

    // Called at a negedge: applies one request, returns at the next negedge with the model advanced
    task automatic drive(input logic en, input logic [3:0] wen, input logic [31:0] addr,
                         input logic [31:0] wdata);
        logic [31:0] old;
        int          w;
        inst_sram_en    = en;
        inst_sram_wen   = wen;
        inst_sram_addr  = addr;
        inst_sram_wdata = wdata;
        @(negedge clk);
        if (!en) begin
            exp_err = 1'b0;
        end else if (!ok_addr(addr)) begin
            exp_rdata = ERR_WORD;
            exp_err   = 1'b1;
            if (wen == 4'b0) exp_cnt = exp_cnt + 1;
        end else begin
            w   = word_of(addr);
            old = mref.exists(w) ? mref[w] : 32'hxxxx_xxxx;
            exp_rdata = old;
            exp_err   = 1'b0;
            if (wen == 4'b0) begin
                exp_cnt = exp_cnt + 1;
            end else begin
                for (int b = 0; b < 4; b++)
                    if (wen[b]) old[8*b +: 8] = wdata[8*b +: 8];
                mref[w] = old;
            end
        end
        inst_sram_en = 1'b0;
    endtask

    task automatic load(input int w, input logic [31:0] data);
        drive(1'b1, 4'hf, 32'hbfc0_0000 + 32'(w * 4), data);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        tests_run++;
        if (inst_sram_rdata !== 32'h0) begin
            tests_failed++; $display("FAIL reset_rdata: got %h want %h", inst_sram_rdata, 32'h0);
        end
        tests_run++;
        if (addr_err !== 1'b0) begin
            tests_failed++; $display("FAIL reset_err: got %b want 0", addr_err);
        end
        tests_run++;
        if (rd_cnt !== 32'h0) begin
            tests_failed++; $display("FAIL reset_cnt: got %0d want 0", rd_cnt);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_read_alias;
        load(0, 32'h3c08bfaf);
        drive(1'b1, 4'h0, 32'hbfc0_0000, 32'h0);
        tests_run++;
        if (inst_sram_rdata !== 32'h3c08bfaf || addr_err !== 1'b0 || rd_cnt !== 32'd1) begin
            tests_failed++;
            $display("FAIL read_kseg1: got %h/%b/%0d want 3c08bfaf/0/1", inst_sram_rdata, addr_err, rd_cnt);
        end
        drive(1'b1, 4'h0, 32'h9fc0_0000, 32'h0);
        tests_run++;
        if (inst_sram_rdata !== 32'h3c08bfaf || addr_err !== 1'b0 || rd_cnt !== 32'd2) begin
            tests_failed++;
            $display("FAIL read_kseg0: got %h/%b/%0d want 3c08bfaf/0/2", inst_sram_rdata, addr_err, rd_cnt);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] want [3];
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        exp_cnt = 0; exp_rdata = 0; exp_err = 0;
        for (int i = 0; i < 3; i++) begin
            want[i] = $urandom;
            load(i, want[i]);
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 4'h0, 32'hbfc0_0000 + 32'(i * 4), 32'h0);
            tests_run++;
            if (inst_sram_rdata !== want[i]) begin
                tests_failed++;
                $display("FAIL b2b_rdata[%0d]: got %h want %h", i, inst_sram_rdata, want[i]);
            end
        end
        tests_run++;
        if (rd_cnt !== 32'd3) begin
            tests_failed++; $display("FAIL b2b_cnt: got %0d want 3", rd_cnt);
        end
    endtask

    task automatic test_byte_write;
        load(1, 32'h11223344);
        drive(1'b1, 4'b0011, 32'hbfc0_0004, 32'hdeadbeef);
        tests_run++;
        if (inst_sram_rdata !== 32'h11223344 || addr_err !== 1'b0 || rd_cnt !== exp_cnt) begin
            tests_failed++;
            $display("FAIL write_read_first: got %h/%b/%0d want 11223344/0/%0d",
                     inst_sram_rdata, addr_err, rd_cnt, exp_cnt);
        end
        drive(1'b1, 4'h0, 32'hbfc0_0004, 32'h0);
        tests_run++;
        if (inst_sram_rdata !== 32'h1122beef || rd_cnt !== exp_cnt) begin
            tests_failed++;
            $display("FAIL byte_merge: got %h/%0d want 1122beef/%0d", inst_sram_rdata, rd_cnt, exp_cnt);
        end
    endtask

    task automatic test_idle_hold;
        load(0, 32'haaaa5555);
        drive(1'b1, 4'h0, 32'hbfc0_0000, 32'h0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 4'h0, (i % 2) ? 32'hbfc0_0004 : 32'h1234_5678, 32'h0);
            tests_run++;
            if (inst_sram_rdata !== 32'haaaa5555 || addr_err !== 1'b0) begin
                tests_failed++;
                $display("FAIL idle_hold[%0d]: got %h/%b want aaaa5555/0", i, inst_sram_rdata, addr_err);
            end
        end
    endtask

    task automatic test_addr_err;
        logic [31:0] bad [2];
        bad[0] = 32'hbfc1_0000;
        bad[1] = 32'hbfc0_0002;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 4'h0, bad[i], 32'h0);
            tests_run++;
            if (inst_sram_rdata !== ERR_WORD || addr_err !== 1'b1 || rd_cnt !== exp_cnt) begin
                tests_failed++;
                $display("FAIL err_read[%0d]: got %h/%b/%0d want %h/1/%0d",
                         i, inst_sram_rdata, addr_err, rd_cnt, ERR_WORD, exp_cnt);
            end
            drive(1'b0, 4'h0, 32'h0, 32'h0);
            tests_run++;
            if (addr_err !== 1'b0) begin
                tests_failed++; $display("FAIL err_one_cycle[%0d]: got %b want 0", i, addr_err);
            end
        end
        drive(1'b1, 4'hf, 32'hbfc1_0000, 32'h0bad_0bad);
        tests_run++;
        if (addr_err !== 1'b1) begin
            tests_failed++; $display("FAIL err_write_flag: got %b want 1", addr_err);
        end
        drive(1'b1, 4'h0, 32'hbfc0_0000, 32'h0);
        tests_run++;
        if (inst_sram_rdata !== 32'haaaa5555) begin
            tests_failed++; $display("FAIL err_write_no_effect: got %h want aaaa5555", inst_sram_rdata);
        end
    endtask

    task automatic test_reset_midstream;
        inst_sram_en   = 1'b1;
        inst_sram_wen  = 4'h0;
        inst_sram_addr = 32'hbfc0_0004;
        #2 reset = 1'b1;
        #1;
        tests_run++;
        if (inst_sram_rdata !== 32'h0 || addr_err !== 1'b0 || rd_cnt !== 32'h0) begin
            tests_failed++;
            $display("FAIL async_reset: got %h/%b/%0d want 0/0/0", inst_sram_rdata, addr_err, rd_cnt);
        end
        @(negedge clk);
        tests_run++;
        if (rd_cnt !== 32'h0) begin
            tests_failed++; $display("FAIL reset_discard: got %0d want 0", rd_cnt);
        end
        reset = 1'b0;
        inst_sram_en = 1'b0;
        exp_rdata = 0; exp_err = 0; exp_cnt = 0;
        drive(1'b1, 4'h0, 32'hbfc0_0004, 32'h0);
        tests_run++;
        if (inst_sram_rdata !== 32'h1122beef || rd_cnt !== 32'd1) begin
            tests_failed++;
            $display("FAIL mem_survives_reset: got %h/%0d want 1122beef/1", inst_sram_rdata, rd_cnt);
        end
    endtask

    task automatic test_random;
        logic [31:0] a;
        logic [3:0]  wen;
        logic        en;
        int          kind;
        for (int w = 0; w < 64; w++) load(w, $urandom);
        for (int n = 0; n < 300; n++) begin
            kind = $urandom_range(0, 9);
            en   = ($urandom_range(0, 5) != 0);
            wen  = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
            case (kind)
                7:       a = {3'($urandom), 29'h1fc0_0000 + 29'($urandom_range(0, 63) * 4 + $urandom_range(1, 3))};
                8:       a = {3'($urandom), 29'h1fc1_0000 + 29'($urandom_range(0, 63) * 4)};
                9:       a = {3'($urandom), 29'h1fbf_fffc - 29'($urandom_range(0, 15) * 4)};
                default: a = {3'($urandom), 29'h1fc0_0000 + 29'($urandom_range(0, 63) * 4)};
            endcase
            drive(en, wen, a, $urandom);
            tests_run++;
            if (inst_sram_rdata !== exp_rdata || addr_err !== exp_err || rd_cnt !== exp_cnt) begin
                tests_failed++;
                $display("FAIL random[%0d] addr=%h en=%b wen=%h: got %h/%b/%0d want %h/%b/%0d",
                         n, a, en, wen, inst_sram_rdata, addr_err, rd_cnt, exp_rdata, exp_err, exp_cnt);
            end
        end
    endtask

    initial begin
        test_reset;
        test_read_alias;
        test_back_to_back;
        test_byte_write;
        test_idle_hold;
        test_addr_err;
        test_reset_midstream;
        test_random;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
